int_to_fp_converter: RTL and testbench



---
 rtl/int_to_fp_converter_pkg.sv | 9 +
 rtl/fp16_round_pack.sv | 30 +++
 rtl/int_to_fp_converter.sv | 97 +++++++++
 tb/tb_int_to_fp_converter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/int_to_fp_converter_pkg.sv
// int_to_fp_converter_pkg: fp16 format constants, rounding modes and converter state encoding
package int_to_fp_converter_pkg;
  localparam int FP16_EXP_W  = 5;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_BIAS   = 15;
  localparam int ROUND_TRUNC = 0;
  localparam int ROUND_RNE   = 1;
  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND, S_DONE} state_e;
endpackage

// File: rtl/fp16_round_pack.sv
// fp16_round_pack: rounds a normalised 16-bit magnitude and packs it into an fp16 word
module fp16_round_pack
  import int_to_fp_converter_pkg::*;
#(
  parameter int EXP_BIAS   = FP16_BIAS,
  parameter int ROUND_MODE = ROUND_RNE
) (
  input  logic [14:0] mag_i,
  input  logic [3:0]  sc_i,
  input  logic        sign_i,
  output logic [15:0] r_o,
  output logic        inexact_o
);
  logic [FP16_MANT_W-1:0] mant;
  logic [FP16_MANT_W:0]   mant_sum;
  logic [FP16_EXP_W-1:0]  expo;
  logic                   guard, sticky, inc;
  // mag_i excludes the implicit leading one; a mantissa carry-out bumps the exponent
  always_comb begin
    mant      = mag_i[14:5];
    guard     = mag_i[4];
    sticky    = |mag_i[3:0];
    inc       = (ROUND_MODE != ROUND_TRUNC) && guard && (sticky || mant[0]);
    mant_sum  = {1'b0, mant} + {{FP16_MANT_W{1'b0}}, inc};
    expo      = FP16_EXP_W'(EXP_BIAS + 15) - {1'b0, sc_i}
              + {{(FP16_EXP_W-1){1'b0}}, mant_sum[FP16_MANT_W]};
    r_o       = {sign_i, expo, mant_sum[FP16_MANT_W-1:0]};
    inexact_o = guard | sticky;
  end
endmodule

// File: rtl/int_to_fp_converter.sv
// int_to_fp_converter: multi-cycle 16-bit signed integer to fp16 converter with start/busy/done
module int_to_fp_converter
  import int_to_fp_converter_pkg::*;
#(
  parameter int EXP_BIAS   = FP16_BIAS,
  parameter int ROUND_MODE = ROUND_RNE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] x,
  output logic        busy,
  output logic        done,
  output logic [15:0] r,
  output logic        negative,
  output logic        zero,
  output logic        inexact
);
  state_e      state_q, state_d;
  logic [15:0] mag_q, mag_d, r_q, r_d, abs_x, rp_r;
  logic [3:0]  sc_q, sc_d;
  logic        sign_q, sign_d, neg_q, neg_d, zero_q, zero_d, inexact_q, inexact_d, rp_inexact;

  assign abs_x = x[15] ? -x : x;

  fp16_round_pack #(.EXP_BIAS(EXP_BIAS), .ROUND_MODE(ROUND_MODE)) u_round_pack (
    .mag_i    (mag_q[14:0]),
    .sc_i     (sc_q),
    .sign_i   (sign_q),
    .r_o      (rp_r),
    .inexact_o(rp_inexact)
  );

  // state, datapath and result registers; reset abandons any conversion in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      mag_q     <= '0;
      sc_q      <= '0;
      sign_q    <= 1'b0;
      r_q       <= '0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      sc_q      <= sc_d;
      sign_q    <= sign_d;
      r_q       <= r_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      inexact_q <= inexact_d;
    end
  end

  // next state: zero operands skip NORM and are packed as +0 in ROUND so latency stays at 2
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    sc_d      = sc_q;
    sign_d    = sign_q;
    r_d       = r_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    inexact_d = inexact_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        sign_d  = x[15];
        mag_d   = abs_x;
        sc_d    = '0;
        state_d = (abs_x == '0) ? S_ROUND : S_NORM;
      end
      S_NORM: begin
        state_d = mag_q[15] ? S_ROUND : S_NORM;
        mag_d   = mag_q[15] ? mag_q : mag_q << 1;
        sc_d    = mag_q[15] ? sc_q : sc_q + 4'd1;
      end
      S_ROUND: begin
        r_d       = (mag_q == '0) ? '0 : rp_r;
        inexact_d = (mag_q != '0) && rp_inexact;
        neg_d     = r_d[15];
        zero_d    = (r_d == '0);
        state_d   = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign r        = r_q;
  assign negative = neg_q;
  assign zero     = zero_q;
  assign inexact  = inexact_q;
endmodule

// File: tb/tb_int_to_fp_converter.sv
// tb_int_to_fp_converter: directed checks of the RNE and truncating converters driven in parallel
module tb_int_to_fp_converter;
  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [15:0] x;
  logic        busy_r, done_r, neg_r, zero_r, inex_r;
  logic        busy_t, done_t, neg_t, zero_t, inex_t;
  logic [15:0] r_r, r_t;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  int_to_fp_converter #(.EXP_BIAS(15), .ROUND_MODE(1)) dut_rne (
    .clk(clk), .reset_n(reset_n), .start(start), .x(x),
    .busy(busy_r), .done(done_r), .r(r_r), .negative(neg_r), .zero(zero_r), .inexact(inex_r)
  );

  int_to_fp_converter #(.EXP_BIAS(15), .ROUND_MODE(0)) dut_trunc (
    .clk(clk), .reset_n(reset_n), .start(start), .x(x),
    .busy(busy_t), .done(done_t), .r(r_t), .negative(neg_t), .zero(zero_t), .inexact(inex_t)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic [15:0] xv, input logic [15:0] er,
                     input logic [15:0] et, input logic ei, input int lat);
    int n;
    @(negedge clk);
    x     = xv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = ~xv;
    n     = 1;
    while (!done_r && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_r"}, r_r, er);
    check({tag, "_rt"}, r_t, et);
    check({tag, "_inex"}, inex_r, ei);
    check({tag, "_inext"}, inex_t, ei);
    check({tag, "_neg"}, neg_r, er[15]);
    check({tag, "_zero"}, zero_r, er == 16'h0);
    check({tag, "_donet"}, done_t, 1);
    @(posedge clk);
    #1;
    check({tag, "_done_w"}, done_r, 0);
  endtask

  initial begin
    int cnt, n;
    reset_n = 1'b0;
    start   = 1'b0;
    x       = 16'h0;
    #2;
    check("rst_busy", busy_r, 0);
    check("rst_done", done_r, 0);
    check("rst_r", r_r, 16'h0);
    check("rst_flags", {neg_r, zero_r, inex_r}, 3'b000);
    @(negedge clk);
    reset_n = 1'b1;

    run("p1",    16'd1,     16'h3C00, 16'h3C00, 1'b0, 18);
    run("m1",    16'hFFFF,  16'hBC00, 16'hBC00, 1'b0, 18);
    run("z",     16'd0,     16'h0000, 16'h0000, 1'b0, 2);
    run("k1000", 16'd1000,  16'h63D0, 16'h63D0, 1'b0, 9);
    run("t2049", 16'd2049,  16'h6800, 16'h6800, 1'b1, 7);
    run("t2051", 16'd2051,  16'h6802, 16'h6801, 1'b1, 7);
    run("max",   16'd32767, 16'h7800, 16'h77FF, 1'b1, 4);
    run("min",   16'h8000,  16'hF800, 16'hF800, 1'b0, 3);
    run("m1000", 16'hFC18,  16'hE3D0, 16'hE3D0, 1'b0, 9);

    // start while busy must be ignored
    @(negedge clk);
    x     = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("ign_busy", busy_r, 1);
    @(negedge clk);
    x     = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done_r && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ign_done", done_r, 1);
    check("ign_r", r_r, 16'h3C00);
    repeat (3) @(posedge clk);
    #1;
    check("ign_hold_r", r_r, 16'h3C00);
    check("ign_idle", busy_r, 0);

    // start held high: back-to-back conversions, each done one cycle wide
    @(negedge clk);
    x     = 16'h8000;
    start = 1'b1;
    cnt   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done_r) begin
        cnt++;
        check("b2b_r", r_r, 16'hF800);
        @(posedge clk);
        #1;
        i++;
        check("b2b_width", done_r, 0);
      end
    end
    start = 1'b0;
    check("b2b_cnt", cnt, 5);

    // asynchronous reset during NORM
    @(negedge clk);
    x     = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rn_busy_pre", busy_r, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rn_busy", busy_r, 0);
    check("rn_r", r_r, 16'h0);
    check("rn_neg", neg_r, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rn_nodone", done_r, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run("post_rst", 16'd3, 16'h4200, 16'h4200, 1'b0, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
